// File: rtl/usb_packet_buffer_controller.sv
// usb_packet_buffer_controller: USB receive buffer ownership, drop counting and CPU read port
module usb_packet_buffer_controller #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock48,
    input  logic                  reset,
    input  logic                  rx_start,
    input  logic                  rx_write,
    input  logic [DATA_WIDTH-1:0] rx_word,
    input  logic                  rx_end,
    input  logic                  rx_error,
    output logic                  rx_accept,
    input  logic                  cpu_read_valid,
    input  logic [ADDR_WIDTH-1:0] cpu_read_address,
    output logic                  cpu_read_ready,
    output logic [DATA_WIDTH-1:0] cpu_read_data,
    output logic                  cpu_read_data_valid,
    input  logic                  cpu_ack,
    output logic                  packet_ready,
    output logic [ADDR_WIDTH:0]   packet_length,
    output logic [7:0]            dropped_count
);
    typedef enum logic [1:0] {EMPTY, FILLING, READY} state_t;
    localparam logic [ADDR_WIDTH:0] full_count = {1'b1, {ADDR_WIDTH{1'b0}}};
    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   write_index_q, write_index_d;
    logic                  packet_ready_q, packet_ready_d;
    logic [ADDR_WIDTH:0]   packet_length_q, packet_length_d;
    logic [7:0]            dropped_count_q, dropped_count_d;
    logic [DATA_WIDTH-1:0] cpu_read_data_q, cpu_read_data_d;
    logic                  cpu_read_data_valid_q, cpu_read_data_valid_d;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [7:0]            dropped_inc;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    assign rx_accept           = state_q == EMPTY;
    assign cpu_read_ready      = cpu_read_valid && !ram_we;
    assign cpu_read_data       = cpu_read_data_q;
    assign cpu_read_data_valid = cpu_read_data_valid_q;
    assign packet_ready        = packet_ready_q;
    assign packet_length       = packet_length_q;
    assign dropped_count       = dropped_count_q;
    assign dropped_inc         = dropped_count_q != 8'hff ? dropped_count_q + 8'd1 : dropped_count_q;
    // Ownership FSM: the receiver's write always wins the RAM; rx_error beats rx_start beats overflow beats rx_end
    always_comb begin
        state_d         = state_q;
        write_index_d   = write_index_q;
        packet_ready_d  = packet_ready_q;
        packet_length_d = packet_length_q;
        dropped_count_d = dropped_count_q;
        ram_we          = 1'b0;
        ram_waddr       = write_index_q[ADDR_WIDTH-1:0];
        case (state_q)
            EMPTY: begin
                if (rx_start) begin
                    state_d       = FILLING;
                    write_index_d = (ADDR_WIDTH+1)'(rx_write);
                    ram_we        = rx_write;
                    ram_waddr     = '0;
                end
            end
            FILLING: begin
                if (rx_error) begin
                    state_d = EMPTY;
                end else if (rx_start) begin
                    write_index_d = (ADDR_WIDTH+1)'(rx_write);
                    ram_we        = rx_write;
                    ram_waddr     = '0;
                end else if (rx_write && write_index_q == full_count) begin
                    state_d         = EMPTY;
                    dropped_count_d = dropped_inc;
                end else begin
                    ram_we        = rx_write;
                    write_index_d = write_index_q + (ADDR_WIDTH+1)'(rx_write);
                    if (rx_end) begin
                        state_d         = write_index_d != '0 ? READY : EMPTY;
                        packet_ready_d  = write_index_d != '0;
                        packet_length_d = write_index_d != '0 ? write_index_d : packet_length_q;
                    end
                end
            end
            READY: begin
                dropped_count_d = rx_start ? dropped_inc : dropped_count_q;
                state_d         = cpu_ack ? EMPTY : READY;
                packet_ready_d  = !cpu_ack;
            end
            default: state_d = EMPTY;
        endcase
    end
    // CPU read port: one-cycle latency, valid pulses only for accepted reads
    always_comb begin
        cpu_read_data_d       = cpu_read_ready ? mem[cpu_read_address] : cpu_read_data_q;
        cpu_read_data_valid_d = cpu_read_ready;
    end
    // Buffer RAM write port, contents survive reset
    always_ff @(posedge clock48) begin
        if (ram_we) mem[ram_waddr] <= rx_word;
    end
    // State registers with synchronous reset
    always_ff @(posedge clock48) begin
        if (reset) begin
            state_q               <= EMPTY;
            write_index_q         <= '0;
            packet_ready_q        <= 1'b0;
            packet_length_q       <= '0;
            dropped_count_q       <= '0;
            cpu_read_data_q       <= '0;
            cpu_read_data_valid_q <= 1'b0;
        end else begin
            state_q               <= state_d;
            write_index_q         <= write_index_d;
            packet_ready_q        <= packet_ready_d;
            packet_length_q       <= packet_length_d;
            dropped_count_q       <= dropped_count_d;
            cpu_read_data_q       <= cpu_read_data_d;
            cpu_read_data_valid_q <= cpu_read_data_valid_d;
        end
    end
endmodule

// File: tb/tb_usb_packet_buffer_controller.sv
// tb_usb_packet_buffer_controller: directed self-checking bench for the USB packet buffer controller
module tb_usb_packet_buffer_controller;
    logic        clock48 = 1'b0;
    logic        reset;
    logic        rx_start, rx_write, rx_end, rx_error;
    logic [31:0] rx_word;
    logic        rx_accept;
    logic        cpu_read_valid;
    logic [7:0]  cpu_read_address;
    logic        cpu_read_ready;
    logic [31:0] cpu_read_data;
    logic        cpu_read_data_valid;
    logic        cpu_ack;
    logic        packet_ready;
    logic [8:0]  packet_length;
    logic [7:0]  dropped_count;
    int checks = 0;
    int errors = 0;
    usb_packet_buffer_controller dut (
        .clock48(clock48), .reset(reset),
        .rx_start(rx_start), .rx_write(rx_write), .rx_word(rx_word), .rx_end(rx_end), .rx_error(rx_error),
        .rx_accept(rx_accept),
        .cpu_read_valid(cpu_read_valid), .cpu_read_address(cpu_read_address), .cpu_read_ready(cpu_read_ready),
        .cpu_read_data(cpu_read_data), .cpu_read_data_valid(cpu_read_data_valid),
        .cpu_ack(cpu_ack), .packet_ready(packet_ready), .packet_length(packet_length), .dropped_count(dropped_count)
    );
    always #5 clock48 = ~clock48;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic idle();
        rx_start = 0; rx_write = 0; rx_end = 0; rx_error = 0; rx_word = '0;
        cpu_read_valid = 0; cpu_read_address = '0; cpu_ack = 0;
    endtask
    task automatic step();
        @(posedge clock48);
        #1;
        idle();
    endtask
    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask
    task automatic wr(input logic [31:0] w);
        rx_write = 1; rx_word = w;
        step();
    endtask
    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        cpu_read_valid = 1; cpu_read_address = a;
        #1;
        chk({tag, "_rdy"}, 32'(cpu_read_ready), 32'd1);
        step();
        chk({tag, "_vld"}, 32'(cpu_read_data_valid), 32'd1);
        chk(tag, cpu_read_data, exp);
    endtask
    task automatic reset_state(input string tag);
        chk({tag, "_rdy"}, 32'(packet_ready), 32'd0);
        chk({tag, "_len"}, 32'(packet_length), 32'd0);
        chk({tag, "_drop"}, 32'(dropped_count), 32'd0);
        chk({tag, "_acc"}, 32'(rx_accept), 32'd1);
    endtask
    initial begin
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
        reset_state("por");
        chk("por_data", cpu_read_data, 32'h0);
        chk("por_dvld", 32'(cpu_read_data_valid), 32'd0);
        rx_start = 1;
        step();
        chk("fill_acc", 32'(rx_accept), 32'd0);
        wr(32'h11111111);
        wr(32'h22222222);
        wr(32'h33333333);
        rx_end = 1;
        wr(32'h44444444);
        chk("pkt_ready", 32'(packet_ready), 32'd1);
        chk("pkt_len", 32'(packet_length), 32'd4);
        chk("pkt_acc", 32'(rx_accept), 32'd0);
        rd("rd0", 8'd0, 32'h11111111);
        rd("rd1", 8'd1, 32'h22222222);
        rd("rd2", 8'd2, 32'h33333333);
        rd("rd3", 8'd3, 32'h44444444);
        step();
        chk("dvld_pulse", 32'(cpu_read_data_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            rx_start = 1; rx_write = 1; rx_word = 32'hDEADBEEF; rx_end = 1;
            step();
        end
        chk("ready_drop3", 32'(dropped_count), 32'd3);
        chk("ready_acc", 32'(rx_accept), 32'd0);
        rd("ready_keep", 8'd0, 32'h11111111);
        cpu_ack = 1; rx_start = 1;
        step();
        chk("ack_rdy", 32'(packet_ready), 32'd0);
        chk("ack_acc", 32'(rx_accept), 32'd1);
        chk("ack_len", 32'(packet_length), 32'd4);
        chk("ack_drop", 32'(dropped_count), 32'd4);
        cpu_ack = 1;
        step();
        chk("ack_empty_acc", 32'(rx_accept), 32'd1);
        rx_start = 1;
        step();
        for (int c = 0; c < 16; c++) begin
            cpu_read_valid = 1;
            cpu_read_address = 8'(c / 4);
            rx_write = (c % 4) == 0;
            rx_word = 32'hA0000000 + 32'(c);
            #1;
            chk("arb_rdy", 32'(cpu_read_ready), (c % 4) == 0 ? 32'd0 : 32'd1);
            step();
            chk("arb_vld", 32'(cpu_read_data_valid), (c % 4) == 0 ? 32'd0 : 32'd1);
            if ((c % 4) != 0) chk("arb_data", cpu_read_data, 32'hA0000000 + 32'((c / 4) * 4));
        end
        rx_error = 1; rx_end = 1;
        step();
        chk("arb_err_rdy", 32'(packet_ready), 32'd0);
        chk("arb_err_acc", 32'(rx_accept), 32'd1);
        do_reset();
        rx_start = 1;
        step();
        for (int i = 0; i < 256; i++) wr(32'hB0000000 + 32'(i));
        chk("full_acc", 32'(rx_accept), 32'd0);
        wr(32'hCCCCCCCC);
        chk("ovf_acc", 32'(rx_accept), 32'd1);
        chk("ovf_rdy", 32'(packet_ready), 32'd0);
        chk("ovf_drop", 32'(dropped_count), 32'd1);
        rx_start = 1;
        step();
        for (int i = 0; i < 256; i++) wr(32'hB0000000 + 32'(i));
        rx_end = 1;
        step();
        chk("full_rdy", 32'(packet_ready), 32'd1);
        chk("full_len", 32'(packet_length), 32'd256);
        rd("full_rd255", 8'd255, 32'hB00000FF);
        cpu_ack = 1;
        step();
        rx_start = 1;
        step();
        wr(32'hE0000000);
        wr(32'hE0000001);
        rx_error = 1; rx_end = 1; rx_write = 1; rx_word = 32'hE0000002;
        #1;
        chk("err_wr_sup", 32'(cpu_read_valid ? 1'b0 : 1'b1) & 32'd0, 32'd0);
        step();
        chk("err_rdy", 32'(packet_ready), 32'd0);
        chk("err_acc", 32'(rx_accept), 32'd1);
        chk("err_drop", 32'(dropped_count), 32'd1);
        rd("err_old2", 8'd2, 32'hB0000002);
        rd("err_new1", 8'd1, 32'hE0000001);
        rx_start = 1;
        step();
        rx_end = 1;
        step();
        chk("zero_rdy", 32'(packet_ready), 32'd0);
        chk("zero_acc", 32'(rx_accept), 32'd1);
        chk("zero_len", 32'(packet_length), 32'd256);
        rx_start = 1;
        step();
        wr(32'h0F0F0F0F);
        reset = 1;
        step();
        reset = 0;
        reset_state("rst_fill");
        rx_start = 1;
        step();
        rx_end = 1;
        wr(32'h12345678);
        chk("one_len", 32'(packet_length), 32'd1);
        for (int i = 0; i < 260; i++) begin
            rx_start = 1;
            step();
        end
        chk("drop_sat", 32'(dropped_count), 32'd255);
        reset = 1;
        step();
        reset = 0;
        reset_state("rst_ready");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
